// File: rtl/fetch_unit.sv
// 6502 instruction fetch: drives the PC into memory, assembles opcode plus operand
// bytes and presents one whole instruction to control over a valid/ready handshake.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  mem_data,
    output logic [15:0] pc_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    output logic [1:0]  inst_len,
    output logic [15:0] inst_pc,
    input  logic        branch_load,
    input  logic [15:0] branch_target
);

    typedef enum logic [2:0] {S_ISSUE, S_OP, S_LO, S_HI, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_pc, w_pc_nxt;
    logic [15:0] r_inst_pc, w_inst_pc_nxt;
    logic [7:0]  r_opcode, w_opcode_nxt;
    logic [15:0] r_operand, w_operand_nxt;
    logic [1:0]  r_len, w_len_nxt;
    logic [1:0]  w_dec_len;

    function automatic logic [1:0] len_decode(input logic [7:0] op);
        logic [2:0] bbb;
        logic [1:0] l;
        bbb = op[4:2];
        case (op[1:0])
            2'b01:   l = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
            2'b11:   l = 2'd1;
            default: begin
                case (bbb)
                    3'b010, 3'b110: l = 2'd1;
                    3'b011, 3'b111: l = 2'd3;
                    default:        l = 2'd2;
                endcase
            end
        endcase
        // BRK/RTI/RTS are single byte and JSR is absolute despite their bbb field
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) l = 2'd1;
        else if (op == 8'h20)                         l = 2'd3;
        return l;
    endfunction

    assign w_dec_len = len_decode(mem_data);

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_pc_nxt = r_inst_pc;
        w_opcode_nxt  = r_opcode;
        w_operand_nxt = r_operand;
        w_len_nxt     = r_len;
        case (r_state)
            S_ISSUE: begin
                w_inst_pc_nxt = r_pc;
                w_pc_nxt      = r_pc + 16'd1;
                w_state_nxt   = S_OP;
            end
            S_OP: begin
                w_opcode_nxt  = mem_data;
                w_operand_nxt = 16'h0000;
                w_len_nxt     = w_dec_len;
                if (w_dec_len == 2'd1) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_pc_nxt    = r_pc + 16'd1;
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                w_operand_nxt[7:0] = mem_data;
                if (r_len == 2'd3) begin
                    w_pc_nxt    = r_pc + 16'd1;
                    w_state_nxt = S_HI;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HI: begin
                w_operand_nxt[15:8] = mem_data;
                w_state_nxt         = S_HOLD;
            end
            S_HOLD: begin
                // pc already points at the next instruction, so a sequential
                // handshake issues it in the same edge and skips ISSUE
                if (inst_ready) begin
                    if (branch_load) begin
                        w_pc_nxt    = branch_target;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_inst_pc_nxt = r_pc;
                        w_pc_nxt      = r_pc + 16'd1;
                        w_state_nxt   = S_OP;
                    end
                end
            end
            default: w_state_nxt = S_ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_ISSUE;
            r_pc      <= RESET_PC;
            r_inst_pc <= RESET_PC;
            r_opcode  <= 8'h00;
            r_operand <= 16'h0000;
            r_len     <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_opcode  <= w_opcode_nxt;
            r_operand <= w_operand_nxt;
            r_len     <= w_len_nxt;
        end
    end

    assign pc_out     = r_pc;
    assign inst_valid = (r_state == S_HOLD);
    assign opcode     = r_opcode;
    assign operand    = r_operand;
    assign inst_len   = r_len;
    assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected instructions are queued as programs are
// laid into the memory model, then popped and compared when the DUT presents them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_data;
    logic [15:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;
    logic        branch_load;
    logic [15:0] branch_target;

    logic [7:0]  mem [0:65535];

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
        logic [15:0] pc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   lat;

    always #5 clk = ~clk;

    // cpumemory: address sampled at an edge, data valid until the next edge
    always @(posedge clk) mem_data <= mem[pc_out];

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_data(mem_data), .pc_out(pc_out),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .opcode(opcode),
        .operand(operand), .inst_len(inst_len), .inst_pc(inst_pc),
        .branch_load(branch_load), .branch_target(branch_target)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] opnd, input logic [1:0] len,
                        input logic [15:0] pc, input int l);
        exp_t e;
        e.op = op; e.opnd = opnd; e.len = len; e.pc = pc; e.lat = l;
        q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    pc_out,     16'h0000);
        chk({tag, "_vld"},   inst_valid, 1'b0);
        chk({tag, "_op"},    opcode,     8'h00);
        chk({tag, "_opnd"},  operand,    16'h0000);
        chk({tag, "_len"},   inst_len,   2'd0);
        chk({tag, "_ipc"},   inst_pc,    16'h0000);
    endtask

    // Called at a negedge with lat = cycle index of that negedge.
    task automatic wait_check(input string tag);
        exp_t e;
        logic [15:0] nxt;
        while (!inst_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, inst_valid, 1'b1);
        chk({tag, "_sb"}, (q.size() > 0), 1'b1);
        if (q.size() == 0) return;
        e = q.pop_front();
        nxt = e.pc + 16'(e.len);
        chk({tag, "_lat"},  32'(lat), 32'(e.lat));
        chk({tag, "_op"},   opcode,   e.op);
        chk({tag, "_opnd"}, operand,  e.opnd);
        chk({tag, "_len"},  inst_len, e.len);
        chk({tag, "_ipc"},  inst_pc,  e.pc);
        chk({tag, "_pc"},   pc_out,   nxt);
    endtask

    task automatic handshake(input logic br, input logic [15:0] tgt);
        inst_ready = 1'b1; branch_load = br; branch_target = tgt;
        @(negedge clk);
        inst_ready = 1'b0; branch_load = 1'b0; branch_target = 16'h0000;
        lat = 1;
        chk("vld_drop", inst_valid, 1'b0);
        if (br) chk("br_pc", pc_out, tgt);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        lat = 0;
    endtask

    logic [7:0] sweep_op  [12];
    logic [1:0] sweep_len [12];

    initial begin
        sweep_op  = '{8'h00, 8'h20, 8'h40, 8'h4C, 8'h6C, 8'h10, 8'hA2, 8'h8A, 8'h9A, 8'hBE, 8'hB1, 8'h03};
        sweep_len = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        inst_ready = 1'b0; branch_load = 1'b0; branch_target = 16'h0000;
        reset = 1'b0;
        #12;
        chk_reset_vals("rst");

        // single-byte NOP from reset
        push(8'hEA, 16'h0000, 2'd1, 16'h0000, 2);
        release_reset();
        wait_check("nop");

        // LDA #42 ; STA $2000 ; TXA, then stall and branch
        mem[0] = 8'hA9; mem[1] = 8'h42; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'h20;
        mem[5] = 8'h8A; mem[16'h1234] = 8'h60;
        #3 reset = 1'b0;
        push(8'hA9, 16'h0042, 2'd2, 16'h0000, 3);
        release_reset();
        wait_check("lda");
        push(8'h8D, 16'h2000, 2'd3, 16'h0002, 4);
        handshake(1'b0, 16'h0000);
        wait_check("sta");
        push(8'h8A, 16'h0000, 2'd1, 16'h0005, 2);
        handshake(1'b0, 16'h0000);
        wait_check("txa");
        // stray branch_load without ready must be ignored while stalled
        branch_load = 1'b1; branch_target = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_vld",  inst_valid, 1'b1);
            chk("stall_op",   opcode,     8'h8A);
            chk("stall_opnd", operand,    16'h0000);
            chk("stall_ipc",  inst_pc,    16'h0005);
            chk("stall_pc",   pc_out,     16'h0006);
        end
        branch_load = 1'b0;
        push(8'h60, 16'h0000, 2'd1, 16'h1234, 3);
        handshake(1'b1, 16'h1234);
        wait_check("rts");

        // decode sweep, each opcode reached by a branch
        for (int i = 0; i < 12; i++) begin
            logic [15:0] a;
            logic [15:0] o;
            a = 16'h3000 + 16'(i * 4);
            mem[a] = sweep_op[i]; mem[a + 16'd1] = 8'(i + 8'h11); mem[a + 16'd2] = 8'(8'hC0 + i);
            o = 16'h0000;
            if (sweep_len[i] >= 2'd2) o[7:0]  = 8'(i + 8'h11);
            if (sweep_len[i] == 2'd3) o[15:8] = 8'(8'hC0 + i);
            push(sweep_op[i], o, sweep_len[i], a, 32'(sweep_len[i]) + 2);
            handshake(1'b1, a);
            wait_check($sformatf("dec%0d", i));
        end

        // 3-byte instruction straddling the top of memory
        mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        push(8'h4C, 16'h1234, 2'd3, 16'hFFFE, 5);
        handshake(1'b1, 16'hFFFE);
        wait_check("wrap");

        // reset while in LO
        mem[16'h4000] = 8'h8D; mem[16'h4001] = 8'h11; mem[16'h4002] = 8'h22;
        handshake(1'b1, 16'h4000);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midrst");
        mem[0] = 8'hA9; mem[1] = 8'h77;
        push(8'hA9, 16'h0077, 2'd2, 16'h0000, 3);
        release_reset();
        wait_check("restart");

        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 6502 core; sits upstream of memmux and control.
- Drives the program-counter address into memmux pc_in and consumes cpumemory data_out.
- Assembles opcode plus 0–2 operand bytes into one instruction and hands it to control through a valid/ready handshake.
- Owns the PC: sequential increment, plus redirect on branch or jump.

Parameters:
- RESET_PC, 16'h0000, address of the first fetch after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_data  in  8  cpumemory data_out. Synchronous read: an address sampled at edge E gives valid data between E and E+1.
- pc_out  out  16  fetch address to memmux pc_in. Registered.
- inst_valid  out  1  instruction outputs are valid.
- inst_ready  in  1  control accepts the instruction.
- opcode  out  8  fetched opcode.
- operand  out  16  operand bytes: [7:0] is the first operand byte, [15:8] the second. Unused bytes are 0.
- inst_len  out  2  instruction length, 1..3.
- inst_pc  out  16  address of the opcode byte.
- branch_load  in  1  redirect the PC. Sampled only on handshake.
- branch_target  in  16  new PC when branch_load=1.

Behaviour:
- Reset (reset=0, asynchronous): state=ISSUE, pc_out=RESET_PC, inst_valid=0, opcode=0, operand=0, inst_len=0, inst_pc=RESET_PC.
- Reset deasserted mid-instruction: fetch restarts from RESET_PC. No partial instruction is ever presented.
- States: ISSUE, OP, LO, HI, HOLD. Let A be the value of pc_out in each state.
- ISSUE: memory samples A.
  - inst_pc<=A, pc_out<=A+1, go to OP.
- OP: opcode<=mem_data, operand<=0, inst_len<=len(mem_data).
  - len=1: pc_out holds, go to HOLD.
  - len>1: pc_out<=A+1, go to LO.
- LO: operand[7:0]<=mem_data.
  - len=3: pc_out<=A+1, go to HI.
  - len=2: pc_out holds, go to HOLD.
- HI: operand[15:8]<=mem_data, pc_out holds, go to HOLD.
- HOLD: inst_valid=1. pc_out equals the next sequential instruction address N (= inst_pc+inst_len, modulo 2^16). Outputs stay stable until handshake.
- Handshake (inst_valid & inst_ready) in HOLD:
  - branch_load=0: inst_pc<=N, pc_out<=N+1, go to OP. Back-to-back fetch, no ISSUE bubble.
  - branch_load=1: pc_out<=branch_target, go to ISSUE.
  - inst_valid drops the cycle after the handshake.
- branch_load or inst_ready outside HOLD: ignored.
- inst_valid is 1 only in HOLD.
- Arithmetic: all address increments are 16-bit and wrap FFFF->0000.
- Length decode, opcode = aaabbbcc:
  - cc=01: len=3 if bbb is 011, 110 or 111; otherwise len=2.
  - cc=00 or cc=10: bbb 010 or 110 gives 1; bbb 011 or 111 gives 3; all other bbb give 2.
  - Overrides: 00h, 40h and 60h give 1; 20h gives 3.
  - cc=11: len=1.
- Latency from reset release to inst_valid: 2 cycles for len=1, 3 for len=2, 4 for len=3.
- Following instruction after a non-branch handshake: inst_valid rises inst_len+1 cycles after the handshake edge.
- Memory sharing: control must hold memmux on the PC path while the fetch state is ISSUE, OP, LO or HI. It may select the data address only while inst_valid=1, and must return memmux to the PC path no later than the cycle it asserts inst_ready.

Test Plan:
- Memory[0000]=EA, reset then release -> ISSUE, OP, HOLD. inst_valid rises at cycle 2 with opcode=EA, len=1, operand=0000, inst_pc=0000, pc_out=0001.
- Memory[0000..]=A9 42 8D 00 20, inst_ready held 1 -> first instruction LDA#: len=2, operand=0042, inst_pc=0000. Next STA abs: len=3, operand=2000, inst_pc=0002, valid 4 cycles after the first handshake, pc_out=0005.
- inst_ready=0 for 10 cycles in HOLD -> opcode, operand, inst_pc and inst_valid stay stable; pc_out stays constant.
- Handshake with branch_load=1, branch_target=1234, memory[1234]=60 -> passes through ISSUE. Next instruction: opcode=60, len=1, inst_pc=1234.
- Decode sweep over opcodes 00,20,40,4C,6C,10,A2,8A,9A,BE,B1,03 -> len 1,3,1,3,3,2,2,1,1,3,2,1.
- Branch to FFFE with a 3-byte instruction there -> operand bytes read from FFFF and 0000; next pc_out=0001.
- Reset asserted during LO -> all outputs return to reset values immediately; fetch restarts at RESET_PC.
